// File: rtl/ql_ps2_keybuf.sv
// PS/2 keyboard receiver for the QL core: synchronises the PS/2 pair, decodes frames,
// folds E0/F0 prefixes into key events and queues them in a first-word fall-through FIFO.
module ql_ps2_keybuf #(
  parameter int unsigned FIFO_AW = 3,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  input  logic       rd,
  input  logic       overflow_clr,
  output logic [9:0] dout,
  output logic       empty,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

  // Synchroniser flops reset to the idle-high line level so reset never fakes an edge
  logic clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
  logic fall;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_kbd_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_kbd_data;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s2_q;

  rx_state_e       state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TW-1:0]   to_q, to_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    to_d         = to_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (fall) begin
      to_d = '0;
      unique case (state_q)
        StIdle: begin
          if (!dat_s2_q) begin
            state_d  = StData;
            bitcnt_d = 3'd0;
          end
        end
        StData: begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_d   = dat_s2_q;
          state_d = StStop;
        end
        StStop: begin
          // Odd parity over data plus parity bit, and a high stop bit
          if ((^{shift_q, par_q}) && dat_s2_q) byte_valid_d = 1'b1;
          else                                 frame_err_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q == StIdle) begin
      to_d = '0;
    end else if (to_q == TW'(TIMEOUT)) begin
      state_d     = StIdle;
      frame_err_d = 1'b1;
      to_d        = '0;
    end else begin
      to_d = to_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_q         <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_q         <= to_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;

  // Prefix decoder; shift_q still holds the received byte while byte_valid_q is high
  logic       ext_q, ext_d, rel_q, rel_d;
  logic       push;
  logic [9:0] push_data;

  always_comb begin
    ext_d     = ext_q;
    rel_d     = rel_q;
    push      = 1'b0;
    push_data = {rel_q, ext_q, shift_q};
    if (byte_valid_q) begin
      unique case (shift_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: rel_d = 1'b1;
        8'h00, 8'hFF: begin
          ext_d = 1'b0;
          rel_d = 1'b0;
        end
        default: begin
          push  = 1'b1;
          ext_d = 1'b0;
          rel_d = 1'b0;
        end
      endcase
    end
  end

  logic [FIFO_AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [9:0]       mem_q [Depth];
  logic             full, pop_ok, push_ok, drop;
  logic             overflow_q, overflow_d;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                   (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign pop_ok  = rd && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q;
    if (push_ok) wptr_d = wptr_q + (FIFO_AW + 1)'(1);
    if (pop_ok)  rptr_d = rptr_q + (FIFO_AW + 1)'(1);
    if (drop)              overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      ext_q      <= ext_d;
      rel_q      <= rel_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: dout is masked while the pointers say empty
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[FIFO_AW-1:0]] <= push_data;
  end

  assign dout     = empty ? 10'd0 : mem_q[rptr_q[FIFO_AW-1:0]];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ql_ps2_keybuf.sv
// Directed bench for ql_ps2_keybuf: bit-bangs PS/2 frames and checks events, errors and FIFO.
module tb_ql_ps2_keybuf;

  localparam int Half    = 20;
  localparam int Timeout = 4095;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rd = 1'b0;
  logic       ov_clr = 1'b0;
  logic [9:0] dout;
  logic       empty, overflow, frame_err;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  int e0;

  always #5 clk = ~clk;

  ql_ps2_keybuf dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ps2_kbd_clk  (ps2_clk),
    .ps2_kbd_data (ps2_dat),
    .rd           (rd),
    .overflow_clr (ov_clr),
    .dout         (dout),
    .empty        (empty),
    .overflow     (overflow),
    .frame_err    (frame_err)
  );

  // Counts high cycles, so one aborted frame must add exactly one
  always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    total++;
    assert (act === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    tick(Half);
    ps2_clk = 1'b0;
    tick(Half);
    ps2_clk = 1'b1;
  endtask

  // Full frame; optional rd pulse lands on the cycle the event is pushed (edge 4)
  task automatic send_frame(input logic [7:0] b, input logic flip, input logic pop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ flip);
    ps2_dat = 1'b1;
    tick(Half);
    ps2_clk = 1'b0;
    tick(3);
    if (pop) rd = 1'b1;
    tick(1);
    rd = 1'b0;
    tick(Half - 4);
    ps2_clk = 1'b1;
    tick(Half);
  endtask

  task automatic pop_chk(input string tag, input logic [9:0] exp);
    chk(tag, 16'(dout), 16'(exp));
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  initial begin
    logic [7:0] b1c;
    b1c = 8'h1C;
    tick(3);
    chk("rst_dout", 16'(dout), 16'h0);
    chk("rst_empty", 16'(empty), 16'h1);
    chk("rst_ovf", 16'(overflow), 16'h0);
    chk("rst_ferr", 16'(frame_err), 16'h0);
    reset_n = 1'b1;
    tick(Half);

    // 1: single make code with latency check on the stop edge
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b1c[i]);
    ps2_bit(1'b0);
    ps2_dat = 1'b1;
    tick(Half);
    ps2_clk = 1'b0;
    tick(3);
    chk("lat_edge3_empty", 16'(empty), 16'h1);
    tick(1);
    chk("lat_edge4_empty", 16'(empty), 16'h0);
    chk("t1_dout", 16'(dout), 16'h01C);
    tick(Half - 4);
    ps2_clk = 1'b1;
    tick(Half);
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    chk("t1_empty_after_rd", 16'(empty), 16'h1);
    chk("t1_dout_empty", 16'(dout), 16'h0);

    // 2: extended release
    send_frame(8'hE0, 1'b0, 1'b0);
    chk("t2_e0_no_push", 16'(empty), 16'h1);
    send_frame(8'hF0, 1'b0, 1'b0);
    chk("t2_f0_no_push", 16'(empty), 16'h1);
    send_frame(8'h75, 1'b0, 1'b0);
    pop_chk("t2_dout", 10'h375);
    chk("t2_single_event", 16'(empty), 16'h1);

    // 3: parity error then a good frame
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    chk("t3_ferr_pulses", 16'(err_cnt - e0), 16'h1);
    chk("t3_empty", 16'(empty), 16'h1);
    send_frame(8'h1C, 1'b0, 1'b0);
    pop_chk("t3_dout", 10'h01C);
    chk("t3_no_extra_err", 16'(err_cnt - e0), 16'h1);

    // 4: timeout after 5 data bits
    e0 = err_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    ps2_dat = 1'b1;
    tick(Timeout + 10);
    chk("t4_timeout_err", 16'(err_cnt - e0), 16'h1);
    chk("t4_empty", 16'(empty), 16'h1);
    send_frame(8'h29, 1'b0, 1'b0);
    pop_chk("t4_dout", 10'h029);
    chk("t4_err_stable", 16'(err_cnt - e0), 16'h1);

    // 5: overflow, ordering, clear, and full push+pop
    for (int k = 0; k < 9; k++) send_frame(8'(8'h15 + k), 1'b0, 1'b0);
    chk("t5_overflow", 16'(overflow), 16'h1);
    for (int k = 0; k < 8; k++) pop_chk("t5_order", 10'(10'h015 + k));
    chk("t5_drained", 16'(empty), 16'h1);
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    chk("t5_pop_empty", 16'(empty), 16'h1);
    chk("t5_ovf_held", 16'(overflow), 16'h1);
    ov_clr = 1'b1;
    tick(1);
    ov_clr = 1'b0;
    chk("t5_ovf_clr", 16'(overflow), 16'h0);
    for (int k = 0; k < 8; k++) send_frame(8'(8'h15 + k), 1'b0, 1'b0);
    chk("t5_full_no_ovf", 16'(overflow), 16'h0);
    send_frame(8'h1D, 1'b0, 1'b1);
    chk("t5_pushpop_no_ovf", 16'(overflow), 16'h0);
    for (int k = 0; k < 8; k++) pop_chk("t5_order2", 10'(10'h016 + k));
    chk("t5_drained2", 16'(empty), 16'h1);

    // 6: reset mid-frame with events queued
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0);
    chk("t6_queued", 16'(empty), 16'h0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    chk("t6_empty", 16'(empty), 16'h1);
    chk("t6_ovf", 16'(overflow), 16'h0);
    chk("t6_dout", 16'(dout), 16'h0);
    ps2_dat = 1'b1;
    tick(Half);
    send_frame(8'h1C, 1'b0, 1'b0);
    pop_chk("t6_after_rst", 10'h01C);
    chk("t6_final_empty", 16'(empty), 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
